// File: rtl/forex_result_if.sv
// Bus bundle for forex_result_reader: Avalon-MM host side plus the core's path push side.
// Macro FOREX_RESULT_WEIGHT_EN (see the reader) decides whether path_weight is consumed.
`ifndef PRED_WIDTH
`define PRED_WIDTH 7
`endif

interface forex_result_if #(
    parameter int VERT_W = `PRED_WIDTH + 1
);
    logic              chipselect;
    logic              read;
    logic              write;
    logic [2:0]        address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;

    logic              path_valid;
    logic [VERT_W-1:0] path_vertex;
    logic              path_last;
    logic [31:0]       path_weight;
    logic              path_ready;

    modport master (
        output chipselect, read, write, address, writedata,
        output path_valid, path_vertex, path_last, path_weight,
        input  readdata, irq, path_ready
    );

    modport slave (
        input  chipselect, read, write, address, writedata,
        input  path_valid, path_vertex, path_last, path_weight,
        output readdata, irq, path_ready
    );
endinterface

// File: rtl/forex_result_reader.sv
// FIFO of negative-cycle vertices drained by popping Avalon DATA reads; irq while a whole cycle is buffered.
// Define FOREX_RESULT_WEIGHT_EN to store path_weight per entry and expose the last popped weight at addr 2.
`ifndef PRED_WIDTH
`define PRED_WIDTH 7
`endif

module forex_result_reader #(
    parameter int VERT_W = `PRED_WIDTH + 1,
    parameter int DEPTH  = 16
) (
    input logic           clk,
    input logic           reset,
    forex_result_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_DATA    = 3'd1;
    localparam logic [2:0] ADDR_WEIGHT  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;

    logic [VERT_W-1:0] r_mem_vert [DEPTH];
    logic              r_mem_last [DEPTH];
`ifdef FOREX_RESULT_WEIGHT_EN
    logic [31:0]       r_mem_wt   [DEPTH];
    logic [31:0]       r_weight;
`endif

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_lasts;
    logic             r_overflow;
    logic             r_irq_en;
    logic             r_irq;
    logic [15:0]      r_cycles;
    logic [31:0]      r_readdata;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_ctrl;
    logic             w_flush;
    logic             w_rd;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_push_last;
    logic             w_pop_last;
    logic             w_irq_en_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_lasts_nxt;
    logic [31:0]      w_weight_rd;
    logic [31:0]      w_rd_word;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // A write beats a simultaneous read: the read neither pops nor returns data.
    assign w_wr_ctrl = bus.chipselect && bus.write && (bus.address == ADDR_CONTROL);
    assign w_flush   = w_wr_ctrl && bus.writedata[1];
    assign w_rd      = bus.chipselect && bus.read && !bus.write;
    assign w_pop     = w_rd && (bus.address == ADDR_DATA) && !w_empty;

    // Full is the registered value, so a same-cycle pop never makes room for a push.
    assign w_push      = bus.path_valid && !w_full && !w_flush;
    assign w_drop      = bus.path_valid && w_full && !w_flush;
    assign w_push_last = w_push && bus.path_last;
    assign w_pop_last  = w_pop && r_mem_last[r_rd_ptr];

    assign w_irq_en_nxt = w_wr_ctrl ? bus.writedata[0] : r_irq_en;

`ifdef FOREX_RESULT_WEIGHT_EN
    assign w_weight_rd = r_weight;
`else
    assign w_weight_rd = '0;
`endif

    always_comb begin
        w_count_nxt = r_count;
        if (w_flush) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_comb begin
        w_lasts_nxt = r_lasts;
        if (w_flush) begin
            w_lasts_nxt = '0;
        end else begin
            w_lasts_nxt = r_lasts + CNT_W'(w_push_last) - CNT_W'(w_pop_last);
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (w_rd) begin
            case (bus.address)
                ADDR_STATUS:  w_rd_word = {r_cycles, 8'(r_count), 4'b0000,
                                           r_irq_en, r_overflow, w_full, !w_empty};
                ADDR_DATA:    if (!w_empty) begin
                                  w_rd_word = {r_mem_last[r_rd_ptr], 1'b1, 30'(r_mem_vert[r_rd_ptr])};
                              end
                ADDR_WEIGHT:  w_rd_word = w_weight_rd;
                ADDR_CONTROL: w_rd_word = {31'b0, r_irq_en};
                default:      w_rd_word = '0;
            endcase
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_vert[r_wr_ptr] <= bus.path_vertex;
            r_mem_last[r_wr_ptr] <= bus.path_last;
`ifdef FOREX_RESULT_WEIGHT_EN
            r_mem_wt[r_wr_ptr]   <= bus.path_weight;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lasts    <= '0;
            r_overflow <= 1'b0;
            r_irq_en   <= 1'b0;
            r_irq      <= 1'b0;
            r_cycles   <= '0;
            r_readdata <= '0;
        end else begin
            r_count    <= w_count_nxt;
            r_lasts    <= w_lasts_nxt;
            r_irq_en   <= w_irq_en_nxt;
            r_irq      <= w_irq_en_nxt && (w_lasts_nxt != '0);
            r_readdata <= w_rd_word;
            if (w_flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_overflow <= 1'b0;
                r_cycles   <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                if (w_push_last && (r_cycles != 16'hFFFF)) begin
                    r_cycles <= r_cycles + 16'd1;
                end
            end
        end
    end

`ifdef FOREX_RESULT_WEIGHT_EN
    // Weight latch survives a flush; only reset or the next pop changes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_weight <= '0;
        end else if (w_pop) begin
            r_weight <= r_mem_wt[r_rd_ptr];
        end
    end
`endif

    assign bus.readdata   = r_readdata;
    assign bus.irq        = r_irq;
    assign bus.path_ready = !w_full;

endmodule

// File: tb/tb_forex_result_reader.sv
// Self-checking bench for forex_result_reader: directed scenarios plus randomized traffic against a queue model.
module tb_forex_result_reader;
    localparam int VERT_W = 8;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    forex_result_if #(.VERT_W(VERT_W)) bus();

    forex_result_reader #(.VERT_W(VERT_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic              last;
        logic [VERT_W-1:0] vert;
        logic [31:0]       wt;
    } ent_t;

    ent_t        mq[$];
    bit          m_ovf;
    bit          m_ien;
    int          m_cyc;
    logic [31:0] m_wt;

    int checks   = 0;
    int failures = 0;

    function automatic int m_lasts();
        int n = 0;
        foreach (mq[i]) if (mq[i].last) n++;
        return n;
    endfunction

    function automatic logic m_irq();
        return m_ien && (m_lasts() != 0);
    endfunction

    function automatic void m_clear();
        mq.delete();
        m_ovf = 0;
        m_ien = 0;
        m_cyc = 0;
        m_wt  = '0;
    endfunction

    // Drive one clock of stimulus, advance the model, return the readdata expected after the edge.
    task automatic cyc(input bit cs, input bit rd, input bit wr, input logic [2:0] addr,
                       input logic [31:0] wd, input bit pv, input logic [VERT_W-1:0] v,
                       input bit pl, input logic [31:0] pw, output logic [31:0] exp_rd);
        bit   full;
        bit   flush;
        ent_t e;
        bus.chipselect  = cs;
        bus.read        = rd;
        bus.write       = wr;
        bus.address     = addr;
        bus.writedata   = wd;
        bus.path_valid  = pv;
        bus.path_vertex = v;
        bus.path_last   = pl;
        bus.path_weight = pw;
        full  = (mq.size() == DEPTH);
        flush = cs && wr && (addr == 3'd3) && wd[1];
        exp_rd = '0;
        if (cs && rd && !wr) begin
            case (addr)
                3'd0: exp_rd = {16'(m_cyc), 8'(mq.size()), 4'b0000, m_ien, m_ovf, full, mq.size() != 0};
                3'd1: if (mq.size() != 0) begin
                          e = mq.pop_front();
                          exp_rd = {e.last, 1'b1, 30'(e.vert)};
`ifdef FOREX_RESULT_WEIGHT_EN
                          m_wt = e.wt;
`endif
                      end
                3'd2: exp_rd = m_wt;
                3'd3: exp_rd = {31'b0, m_ien};
                default: exp_rd = '0;
            endcase
        end
        if (cs && wr && addr == 3'd3) begin
            m_ien = wd[0];
            if (wd[1]) begin
                mq.delete();
                m_ovf = 0;
                m_cyc = 0;
            end
        end
        if (pv && !flush) begin
            if (full) m_ovf = 1;
            else begin
                mq.push_back('{pl, v, pw});
                if (pl && m_cyc < 65535) m_cyc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [31:0] dummy;
        reset = 1'b1;
        m_clear();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, dummy);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, dummy);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        do_reset();
        checks++; if (bus.readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=%h", bus.readdata, 32'h0); end
        checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
        checks++; if (bus.path_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.path_ready); end
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=%h", bus.readdata, 32'h0); end
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", bus.readdata, 32'h0); end
    endtask

    task automatic test_basic_cycle();
        logic [31:0] exp;
        logic [31:0] want [3];
        want[0] = 32'h40000003; want[1] = 32'h40000005; want[2] = 32'hC0000007;
        cyc(1, 0, 1, 3, 32'h1, 0, 0, 0, 0, exp);
        cyc(0, 0, 0, 0, 0, 1, 3, 0, 0, exp);
        cyc(0, 0, 0, 0, 0, 1, 5, 0, 0, exp);
        checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL basic_irq_early got=%b exp=0", bus.irq); end
        cyc(0, 0, 0, 0, 0, 1, 7, 1, 0, exp);
        checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL basic_irq_rise got=%b exp=1", bus.irq); end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, exp);
            checks++; if (bus.readdata !== want[i]) begin failures++; $display("FAIL basic_data%0d got=%h exp=%h", i, bus.readdata, want[i]); end
        end
        checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL basic_irq_fall got=%b exp=0", bus.irq); end
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata[31:16] !== 16'd1) begin failures++; $display("FAIL basic_cycles got=%0d exp=1", bus.readdata[31:16]); end
        checks++; if (bus.readdata !== exp) begin failures++; $display("FAIL basic_status got=%h exp=%h", bus.readdata, exp); end
    endtask

    task automatic test_overflow_and_simul();
        logic [31:0] exp;
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 0, 0, 1, VERT_W'(i + 1), 0, 0, exp);
        checks++; if (bus.path_ready !== 1'b0) begin failures++; $display("FAIL ovf_ready got=%b exp=0", bus.path_ready); end
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata[15:0] !== {8'(DEPTH), 8'h0F}) begin failures++; $display("FAIL ovf_status got=%h exp=%h", bus.readdata[15:0], {8'(DEPTH), 8'h0F}); end
        // full FIFO: push dropped even though a pop happens this cycle
        cyc(1, 1, 0, 1, 0, 1, 8'hAA, 0, 0, exp);
        checks++; if (bus.readdata !== 32'h40000001) begin failures++; $display("FAIL full_simul_data got=%h exp=%h", bus.readdata, 32'h40000001); end
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata[15:8] !== 8'(DEPTH - 1)) begin failures++; $display("FAIL full_simul_count got=%0d exp=%0d", bus.readdata[15:8], DEPTH - 1); end
        for (int i = 1; i < DEPTH; i++) begin
            cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, exp);
            checks++; if (bus.readdata !== (32'h40000000 | 32'(i + 1))) begin failures++; $display("FAIL ovf_order%0d got=%h exp=%h", i, bus.readdata, 32'h40000000 | 32'(i + 1)); end
        end
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata !== 32'h0) begin failures++; $display("FAIL ovf_drained got=%h exp=0", bus.readdata); end
        // empty FIFO: pop returns nothing, push lands
        cyc(1, 1, 0, 1, 0, 1, 9, 0, 0, exp);
        checks++; if (bus.readdata !== 32'h0) begin failures++; $display("FAIL empty_simul_data got=%h exp=0", bus.readdata); end
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata[15:8] !== 8'd1) begin failures++; $display("FAIL empty_simul_count got=%0d exp=1", bus.readdata[15:8]); end
        checks++; if (bus.readdata !== exp) begin failures++; $display("FAIL empty_simul_status got=%h exp=%h", bus.readdata, exp); end
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata !== 32'h40000009) begin failures++; $display("FAIL empty_simul_pop got=%h exp=%h", bus.readdata, 32'h40000009); end
    endtask

    task automatic test_flush();
        logic [31:0] exp;
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 0, 0, 1, VERT_W'(i), (i % 4) == 3, 0, exp);
        checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL flush_irq_before got=%b exp=1", bus.irq); end
        cyc(1, 0, 1, 3, 32'h3, 1, 8'h55, 1, 0, exp);
        checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL flush_irq_after got=%b exp=0", bus.irq); end
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata !== 32'h00000008) begin failures++; $display("FAIL flush_status got=%h exp=%h", bus.readdata, 32'h8); end
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata !== 32'h0) begin failures++; $display("FAIL flush_data got=%h exp=0", bus.readdata); end
        cyc(1, 1, 1, 3, 32'h0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata !== 32'h0) begin failures++; $display("FAIL rdwr_clash got=%h exp=0", bus.readdata); end
        cyc(1, 1, 0, 3, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata !== 32'h0) begin failures++; $display("FAIL ctrl_read got=%h exp=0", bus.readdata); end
    endtask

    task automatic test_weight();
        logic [31:0] exp;
        logic [31:0] want_wt;
`ifdef FOREX_RESULT_WEIGHT_EN
        want_wt = 32'hFFFFFF80;
`else
        want_wt = 32'h0;
`endif
        cyc(0, 0, 0, 0, 0, 1, 2, 1, 32'hFFFFFF80, exp);
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata !== 32'hC0000002) begin failures++; $display("FAIL weight_data got=%h exp=%h", bus.readdata, 32'hC0000002); end
        cyc(1, 1, 0, 2, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata !== want_wt) begin failures++; $display("FAIL weight_reg got=%h exp=%h", bus.readdata, want_wt); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] exp;
        cyc(1, 0, 1, 3, 32'h1, 1, 4, 1, 0, exp);
        cyc(0, 0, 0, 0, 0, 1, 6, 0, 0, exp);
        cyc(1, 1, 0, 0, 0, 1, 8, 0, 0, exp);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.readdata !== 32'h0 || bus.irq !== 1'b0 || bus.path_ready !== 1'b1)
            begin failures++; $display("FAIL midreset_outputs got=%h/%b/%b exp=0/0/1", bus.readdata, bus.irq, bus.path_ready); end
        do_reset();
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, exp);
        checks++; if (bus.readdata !== 32'h0) begin failures++; $display("FAIL midreset_status got=%h exp=0", bus.readdata); end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        logic [31:0] wd;
        bit cs, rd, wr, pv;
        int r;
        for (int n = 0; n < 800; n++) begin
            cs = ($urandom_range(7) != 0);
            r  = $urandom_range(99);
            rd = (r < 55) || (r >= 95);
            wr = (r >= 85);
            wd = $urandom;
            if ($urandom_range(24) != 0) wd[1] = 1'b0;
            pv = (n < 400) ? ($urandom_range(9) < 7) : ($urandom_range(9) < 3);
            cyc(cs, rd, wr, 3'($urandom_range(7)), wd, pv, VERT_W'($urandom),
                $urandom_range(3) == 0, $urandom, exp);
            checks++; if (bus.readdata !== exp) begin failures++; $display("FAIL rand_readdata n=%0d got=%h exp=%h", n, bus.readdata, exp); end
            checks++; if (bus.irq !== m_irq()) begin failures++; $display("FAIL rand_irq n=%0d got=%b exp=%b", n, bus.irq, m_irq()); end
            checks++; if (bus.path_ready !== (mq.size() != DEPTH)) begin failures++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, bus.path_ready, mq.size() != DEPTH); end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_basic_cycle();
        test_overflow_and_simul();
        test_flush();
        test_weight();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/forex_result_reader.md
# forex_result_reader

Host-facing Avalon-MM read-side responder for the FOREX arbitrage engine: complements the edge-update write port by returning results to software. Accepts negative-cycle vertex streams from the Bellman-Ford container over a valid/ready push interface and buffers them in a FIFO. Software drains the FIFO through popping register reads. It raises a level interrupt while at least one complete cycle is buffered.

## Interface
- VERT_W, default `PRED_WIDTH+1: vertex index width.
- DEPTH, default 16: FIFO entries; power of two, ≥2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- chipselect  in  1  Avalon slave select.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- address  in  3  register word address.
- writedata  in  32  write data.
- readdata  out  32  read data, registered, fixed read latency 1.
- irq  out  1  level interrupt.
- path_valid  in  1  core presents a cycle vertex.
- path_vertex  in  VERT_W  vertex index.
- path_last  in  1  final vertex of the current cycle.
- path_weight  in  32  accumulated cycle weight; used only with FOREX_RESULT_WEIGHT_EN.
- path_ready  out  1  = !full; advisory, because the core is not required to stall.

## Operation
- Entry = {last, vertex[, weight]}. Circular FIFO with read/write pointers of log2(DEPTH) bits that wrap naturally. count is $clog2(DEPTH+1) bits.
- Push: the push condition is path_valid && !full && !flush_now. If path_valid && full, the entry is dropped and sticky overflow is set. Full is the registered value, so a push into a full FIFO is dropped even if a pop happens in the same cycle.
- On every accepted push with last=1: lasts_pending increments, and cycles_done (16-bit) increments, saturating at 0xFFFF.
- Register map, accessed when chipselect=1:
  - addr 0 STATUS (read): [0] !empty, [1] full, [2] overflow, [3] irq_en, [15:8] count, [31:16] cycles_done.
  - addr 1 DATA (read, pops the FIFO): [31] last, [30] valid, [VERT_W-1:0] vertex. If the FIFO is empty it returns 0 and does not pop. A pop of a last=1 entry decrements lasts_pending.
  - addr 2 WEIGHT (read): weight of the entry most recently popped via addr 1. Returns 0 when the macro is absent.
  - addr 3 CONTROL: a write sets irq_en from bit0. writedata[1]=1 is a flush: it clears the FIFO, count, lasts_pending, overflow and cycles_done; irq_en is retained. A read of addr 3 returns {31'b0, irq_en}.
  - All other addresses read 0; writes to them are ignored.
- irq = irq_en && (lasts_pending != 0).
- Simultaneous events:
  - Push + pop when not full: count is unchanged.
  - Push + pop when empty: the pop returns valid=0 and the push lands, so count becomes 1.
  - Flush + path_valid: flush wins, the push is discarded and overflow is not set.
  - lasts_pending is adjusted for both edges in the same cycle.
- A read and a write on the same cycle is not a legal Avalon transaction. The write takes priority; the read returns 0 and does not pop.

## Timing
- Reset (asynchronous, active-high):
  - pointers, count, lasts_pending, overflow, cycles_done, irq_en and the weight latch are all 0.
  - readdata=0, irq=0, path_ready=1.
- Read latency 1: readdata is valid on the cycle after read && chipselect. The pop and the pointer update take effect on the read cycle's edge.
- A push is visible in STATUS on a read issued the cycle after acceptance.
- irq updates one cycle after the push/pop/flush/CONTROL write that changes it. No waitrequest is used; all accesses complete in one cycle.
- Back-to-back DATA reads pop consecutive entries, one per cycle.
- Reset asserted mid-stream aborts everything, and partial cycles are discarded.

## Configuration
- FOREX_RESULT_WEIGHT_EN defined:
  - each FIFO entry stores path_weight.
  - every DATA pop latches the popped entry's weight into the WEIGHT register; addr 2 returns it.
- Undefined:
  - no weight storage.
  - path_weight is ignored.
  - addr 2 reads 0.

## Test plan
- Reset, then read addr 0 and addr 1 -> STATUS=0x00000000, DATA=0x00000000, irq=0, path_ready=1.
- Write CONTROL=0x1; push vertices 3,5,7 with last on 7; read DATA ×3:
  - irq rises one cycle after the last push.
  - reads return 0x40000003, 0x40000005, 0xC0000007.
  - irq falls after the third read.
  - STATUS[31:16]=1.
- Push DEPTH+2 entries with no reads -> full=1, path_ready=0, overflow=1, count=DEPTH. The first DEPTH vertices read back in order, then DATA=0.
- With a full FIFO, push and pop in the same cycle -> push dropped, count=DEPTH-1. With an empty FIFO, push+pop -> DATA=0, count=1.
- Write CONTROL=0x3 while path_valid=1 -> FIFO empty, overflow=0, cycles_done=0, irq_en=1, push not stored.
- With macro defined: push vertex 2 with weight 0xFFFFFF80 and last=1; read DATA, then WEIGHT -> 0xC0000002, then 0xFFFFFF80.
